// File: rtl/snake_body_scanner.sv
//------------------------------------------------------------------------------
// snake_body_scanner
//   Holds the snake segment positions in a shift buffer, advances the head on
//   each accepted move tick, then presents every body segment (one per cycle)
//   to an external 20-bit equality comparator and reports a body collision.
//   Position format: pos[19:10] = x, pos[9:0] = y.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   move_tick_i     : one-cycle move request (ignored while busy_o)
//   dir_i[1:0]      : 00 up, 01 down, 10 left, 11 right
//   grow_i          : grow by one segment on the accompanying move
//   head_pos_o      : current head (seg[0]), comparator input A
//   cmp_pos_o       : segment under test, comparator input B (0 when idle)
//   cmp_match_i     : comparator result, same cycle
//   busy_o          : scan in progress
//   scan_done_o     : one-cycle pulse at the end of every scan
//   body_hit_o      : one-cycle pulse with scan_done_o on a collision
//   wall_hit_o      : one-cycle pulse on a rejected off-grid move
//   length_o        : current segment count
//
// Build option:
//   SNAKE_WRAP_EN   : defined   -> coordinates wrap around the grid edges,
//                                  wall_hit_o is constant 0
//                     undefined -> off-grid moves are rejected with wall_hit_o
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module snake_body_scanner #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick_i,
  input  logic [1:0]  dir_i,
  input  logic        grow_i,
  output logic [19:0] head_pos_o,
  output logic [19:0] cmp_pos_o,
  input  logic        cmp_match_i,
  output logic        busy_o,
  output logic        scan_done_o,
  output logic        body_hit_o,
  output logic        wall_hit_o,
  output logic [7:0]  length_o
);

  localparam int         IDXW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [9:0] X_MAX = 10'(GRID_W - 1);
  localparam logic [9:0] Y_MAX = 10'(GRID_H - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] seg_q [MAX_LEN];
  logic [19:0] seg_d [MAX_LEN];
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  last_dir_q, last_dir_d;
  logic        scan_done_q, scan_done_d;
  logic        body_hit_q, body_hit_d;
  logic        wall_hit_q, wall_hit_d;

  logic [1:0]  eff_dir;
  logic [9:0]  hx, hy, nx, ny;
  logic        off_grid;
  logic        wall_reject;

  // Head step. Opposite directions differ only in bit 0, so a reversal
  // request is replaced by the current direction. nx/ny always hold the
  // wrapped coordinate; off_grid flags that a wrap happened.
  always_comb begin
    eff_dir  = dir_i;
    if ((dir_i ^ last_dir_q) == 2'b01) begin
      eff_dir = last_dir_q;
    end
    hx       = seg_q[0][19:10];
    hy       = seg_q[0][9:0];
    nx       = hx;
    ny       = hy;
    off_grid = 1'b0;
    case (eff_dir)
      2'b00: begin
        off_grid = (hy == 10'd0);
        ny       = off_grid ? Y_MAX : hy - 10'd1;
      end
      2'b01: begin
        off_grid = (hy == Y_MAX);
        ny       = off_grid ? 10'd0 : hy + 10'd1;
      end
      2'b10: begin
        off_grid = (hx == 10'd0);
        nx       = off_grid ? X_MAX : hx - 10'd1;
      end
      default: begin
        off_grid = (hx == X_MAX);
        nx       = off_grid ? 10'd0 : hx + 10'd1;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_reject = 1'b0;
`else
  assign wall_reject = off_grid;
`endif

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    last_dir_d  = last_dir_q;
    seg_d       = seg_q;
    scan_done_d = 1'b0;
    body_hit_d  = 1'b0;
    wall_hit_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (move_tick_i) begin
          if (wall_reject) begin
            wall_hit_d = 1'b1;
          end else begin
            seg_d[0] = {nx, ny};
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_d[i] = seg_q[i-1];
            end
            last_dir_d = eff_dir;
            if (grow_i && (len_q < 8'(MAX_LEN))) begin
              len_d = len_q + 8'd1;
            end
            idx_d   = 8'd1;
            state_d = S_SCAN;
          end
        end
      end
      default: begin
        if (cmp_match_i) begin
          scan_done_d = 1'b1;
          body_hit_d  = 1'b1;
          state_d     = S_IDLE;
        end else if (idx_q == (len_q - 8'd1)) begin
          scan_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 8'd0;
      len_q       <= 8'(INIT_LEN);
      last_dir_q  <= 2'b11;
      scan_done_q <= 1'b0;
      body_hit_q  <= 1'b0;
      wall_hit_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_q[i] <= (i < INIT_LEN) ? {10'(GRID_W/2 - i), 10'(GRID_H/2)} : 20'd0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      last_dir_q  <= last_dir_d;
      scan_done_q <= scan_done_d;
      body_hit_q  <= body_hit_d;
      wall_hit_q  <= wall_hit_d;
      seg_q       <= seg_d;
    end
  end

  assign head_pos_o  = seg_q[0];
  assign busy_o      = (state_q == S_SCAN);
  assign cmp_pos_o   = busy_o ? seg_q[idx_q[IDXW-1:0]] : 20'd0;
  assign scan_done_o = scan_done_q;
  assign body_hit_o  = body_hit_q;
  assign wall_hit_o  = wall_hit_q;
  assign length_o    = len_q;

endmodule

`default_nettype wire
